// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned A - B, one bit per clock, LSB first.
// Latency: start accepted at edge N -> WIDTH busy cycles, done pulse in the following FIN cycle.
// Backpressure: start is ignored while busy; a new start is accepted in IDLE or FIN (no queuing).
// Optional feature macro: SUB_OVERFLOW_EN adds a registered two's-complement overflow output.
module serial_subtractor #(
    parameter int WIDTH = 8    // operand/result width, legal range 2..32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    // Bit counter only needs to reach WIDTH-1.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FIN   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // Operand shift registers, borrow flop, internal accumulator and bit counter.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;

    // Registered results presented on the ports.
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;

    // Control decode.
    logic             w_accept;
    logic             w_shift;
    logic             w_last;

    // Half-subtractor-plus-borrow cell.
    logic             w_ai;
    logic             w_bi;
    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_acc_nxt;

`ifdef SUB_OVERFLOW_EN
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_overflow;
`endif

    assign w_last    = (r_cnt == CNT_LAST);
    assign w_ai      = r_a[0];
    assign w_bi      = r_b[0];
    assign w_d       = w_ai ^ w_bi ^ r_borrow;
    assign w_bout    = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_borrow);
    // Result bits enter from the MSB side so after WIDTH shifts bit 0 sits at the bottom.
    assign w_acc_nxt = {w_d, r_acc[WIDTH-1:1]};

    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
`ifdef SUB_OVERFLOW_EN
    assign overflow   = r_overflow;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; FIN accepts a new start just like IDLE.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        w_accept    = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy    = 1'b1;
                w_shift = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                done = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand load on accept, then one bit per cycle through the subtract cell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_acc    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (w_shift) begin
            r_a      <= {1'b0, r_a[WIDTH-1:1]};
            r_b      <= {1'b0, r_b[WIDTH-1:1]};
            r_acc    <= w_acc_nxt;
            r_borrow <= w_bout;
            r_cnt    <= r_cnt + CNT_ONE;
        end
    end

    // Results only move on the last shift edge so the previous answer stays stable meanwhile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else if (w_shift && w_last) begin
            r_diff       <= w_acc_nxt;
            r_borrow_out <= w_bout;
        end
    end

`ifdef SUB_OVERFLOW_EN
    // Signed overflow: operand signs differ and the result sign differs from the minuend's.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_a_msb    <= a[WIDTH-1];
            r_b_msb    <= b[WIDTH-1];
        end else if (w_shift && w_last) begin
            r_overflow <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=8): directed vector table, a strided sweep
// against an arithmetic model, and hand sequences for ignored start, back-to-back
// start in FIN, and reset mid-operation.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SUB_OVERFLOW_EN
    logic         overflow;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SUB_OVERFLOW_EN
        ,
        .overflow   (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at the negedge right after the accepting edge; returns at the done negedge.
    task automatic collect(input string nm, input logic [W-1:0] exp_d,
                           input logic exp_b, input logic exp_o);
        logic [W-1:0] prev;
        int           nbusy;
        bit           held;
        bit           got;
        prev  = diff;
        nbusy = 0;
        held  = 1'b1;
        got   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) nbusy++;
            if (diff !== prev) held = 1'b0;
            @(negedge clk);
        end
        chk({nm, ".done_seen"}, 32'(got), 32'd1);
        chk({nm, ".busy_cycles"}, 32'(nbusy), 32'(W));
        chk({nm, ".diff_held"}, 32'(held), 32'd1);
        chk({nm, ".busy_in_fin"}, 32'(busy), 32'd0);
        chk({nm, ".diff"}, 32'(diff), 32'(exp_d));
        chk({nm, ".borrow"}, 32'(borrow_out), 32'(exp_b));
`ifdef SUB_OVERFLOW_EN
        chk({nm, ".overflow"}, 32'(overflow), 32'(exp_o));
`else
        if (exp_o === 1'bx) $display("note: unexpected x overflow value for %s", nm);
`endif
    endtask

    // Full operation starting and ending on a negedge, with post-done checks.
    task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic [W-1:0] exp_d, input logic exp_b, input logic exp_o);
        start = 1'b1;
        a     = ta;
        b     = tb_;
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        collect(nm, exp_d, exp_b, exp_o);
        @(negedge clk);
        chk({nm, ".done_pulse"}, 32'(done), 32'd0);
        chk({nm, ".diff_after"}, 32'(diff), 32'(exp_d));
    endtask

    initial begin
        int           nd;
        int           nb;
        logic [W-1:0] dv;
        int           sa;
        int           sb;
        int           sd;
        logic [W-1:0] ed;
        logic [15:0]  dfull;

        vecs[0]  = '{8'h35, 8'h12, 8'h23, 1'b0, 1'b0};
        vecs[1]  = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[2]  = '{8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
        vecs[4]  = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
        vecs[5]  = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[6]  = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[7]  = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[8]  = '{8'h01, 8'h02, 8'hFF, 1'b1, 1'b0};
        vecs[9]  = '{8'hAA, 8'h55, 8'h55, 1'b0, 1'b1};
        vecs[10] = '{8'h55, 8'hAA, 8'hAB, 1'b1, 1'b1};
        vecs[11] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.diff", 32'(diff), 32'd0);
        chk("reset.borrow", 32'(borrow_out), 32'd0);
`ifdef SUB_OVERFLOW_EN
        chk("reset.overflow", 32'(overflow), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].diff, vecs[i].borrow, vecs[i].ovf);
        end

        // Strided sweep against an arithmetic reference.
        for (int ia = 0; ia < 256; ia += 17) begin
            for (int ib = 0; ib < 256; ib += 19) begin
                dfull = 16'(ia - ib);
                ed    = dfull[7:0];
                sa    = (ia > 127) ? ia - 256 : ia;
                sb    = (ib > 127) ? ib - 256 : ib;
                sd    = sa - sb;
                run_op($sformatf("sweep_%02h_%02h", ia, ib), 8'(ia), 8'(ib), ed,
                       (ia < ib), (sd > 127) || (sd < -128));
            end
        end

        // Start during SHIFT is ignored: 0x10-0x01 with a 0xFF/0xFF pulse mid-way.
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h01;
        @(negedge clk);
        start = 1'b0;
        nd    = 0;
        nb    = 0;
        dv    = '0;
        for (int i = 0; i < 24; i++) begin
            if (i == 2) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
            end
            if (i == 3) start = 1'b0;
            if (done) begin
                nd++;
                dv = diff;
            end
            if (busy) nb++;
            @(negedge clk);
        end
        chk("ignore.done_count", 32'(nd), 32'd1);
        chk("ignore.busy_cycles", 32'(nb), 32'(W));
        chk("ignore.diff", 32'(dv), 32'h0F);

        // Back-to-back: new start in the FIN cycle begins with no dead cycle.
        start = 1'b1;
        a     = 8'h35;
        b     = 8'h12;
        @(negedge clk);
        start = 1'b0;
        collect("b2b_first", 8'h23, 1'b0, 1'b0);
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h02;
        @(negedge clk);
        start = 1'b0;
        chk("b2b.busy_next", 32'(busy), 32'd1);
        chk("b2b.done_next", 32'(done), 32'd0);
        collect("b2b_second", 8'hFF, 1'b1, 1'b0);
        @(negedge clk);

        // Reset in the middle of an operation.
        run_op("pre_reset", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
        start = 1'b1;
        a     = 8'h44;
        b     = 8'h01;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.diff", 32'(diff), 32'd0);
        chk("midrst.borrow", 32'(borrow_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) nd++;
            if (busy) nb++;
        end
        chk("midrst.no_done", 32'(nd), 32'd0);
        chk("midrst.no_busy", 32'(nb), 32'd0);
        run_op("post_reset", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
